valu_wb_collector: RTL and testbench

Receive side of the vector ALU request stream: accepts result beats emitted by the ALU pipeline for each ALU instruction slot, buffers them in a small FIFO, and drains them into the vector register bank write port under bank back-pressure. Produces the `stall` that throttles the instruction slot's issue, a per-instruction completion pulse, and an idle indication for the vector dispatcher. It sits between the ALU result stage and the register-bank write arbiter.

---
 rtl/rvvLitePkg.sv | 22 ++
 rtl/vWbFifo.sv | 44 ++++
 rtl/valu_wb_collector.sv | 78 +++++++
 tb/tb_valu_wb_collector.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rvvLitePkg.sv
// rvvLitePkg: shared widths and beat/request structs for the vector ALU datapath.
package rvvLitePkg;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 64;
    localparam int DW_B       = DATA_WIDTH / 8;

    typedef struct packed {
        logic [3:0]            op;
        logic [ADDR_WIDTH-1:0] vd;
        logic [DATA_WIDTH-1:0] vs1;
        logic [DATA_WIDTH-1:0] vs2;
        logic                  last;
    } valu_req_t;

    // `last` marks the final beat of an instruction ("end" is a keyword).
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] wbAddr;
        logic [DW_B-1:0]       be;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } vwb_entry_t;
endpackage

// File: rtl/vWbFifo.sv
// vWbFifo: show-ahead FIFO with occupancy count; caller guarantees push only when a slot is free.
module vWbFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push != i_pop) r_count <= i_push ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Output is forced to zero when empty so stale storage never leaks after reset.
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/valu_wb_collector.sv
// valu_wb_collector: buffers ALU result beats and drains them to the register-bank write port,
// generating stall back-pressure, per-instruction completion and a sticky overflow flag.
module valu_wb_collector
    import rvvLitePkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SLACK = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic                  res_end,
    input  logic [ADDR_WIDTH-1:0] res_wbAddr,
    input  logic [DW_B-1:0]       res_be,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  wr_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DW_B-1:0]       wr_be,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  stall,
    output logic                  instr_done,
    output logic                  idle,
    output logic                  overflow_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    vwb_entry_t      w_din;
    vwb_entry_t      w_dout;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            r_stall;
    logic            r_done;
    logic            r_ovf;

    assign w_din = '{wbAddr: res_wbAddr, be: res_be, data: res_data, last: res_end};
    assign w_pop = !w_empty & wr_ready;
    // A full FIFO still accepts a beat when the head drains in the same cycle.
    assign w_push = res_valid & (!w_full | w_pop);
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    vWbFifo #(.WIDTH($bits(vwb_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_stall <= w_count_next >= CW'(DEPTH - SLACK);
            r_done  <= w_pop & w_dout.last;
            r_ovf   <= r_ovf | (res_valid & w_full & !w_pop);
        end
    end

    assign wr_en        = !w_empty;
    assign wr_addr      = w_dout.wbAddr;
    assign wr_be        = w_dout.be;
    assign wr_data      = w_dout.data;
    assign stall        = r_stall;
    assign instr_done   = r_done;
    assign idle         = w_empty & !res_valid;
    assign overflow_err = r_ovf;
endmodule

// File: tb/tb_valu_wb_collector.sv
// tb_valu_wb_collector: randomized + directed scoreboard bench for the write-back collector.
module tb_valu_wb_collector;
    import rvvLitePkg::*;

    localparam int DEPTH = 8;
    localparam int SLACK = 6;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DW_B-1:0]       be;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    typedef struct {
        bit rst;
        bit wr_en;
        bit idle;
        int count;
        bit stall_n;
        bit done_n;
        bit ovf_n;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  res_valid = 1'b0;
    logic                  res_end = 1'b0;
    logic [ADDR_WIDTH-1:0] res_wbAddr = '0;
    logic [DW_B-1:0]       res_be = '0;
    logic [DATA_WIDTH-1:0] res_data = '0;
    logic                  wr_ready = 1'b0;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DW_B-1:0]       wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  stall;
    logic                  instr_done;
    logic                  idle;
    logic                  overflow_err;

    valu_wb_collector #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk          (clk),
        .rst          (rst),
        .res_valid    (res_valid),
        .res_end      (res_end),
        .res_wbAddr   (res_wbAddr),
        .res_be       (res_be),
        .res_data     (res_data),
        .wr_ready     (wr_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_be        (wr_be),
        .wr_data      (wr_data),
        .stall        (stall),
        .instr_done   (instr_done),
        .idle         (idle),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t mq[$];
    beat_t sb[$];
    exp_t  exp_q[$];
    bit    m_ovf = 0;

    function automatic void chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic step(input bit v, input bit e, input logic [ADDR_WIDTH-1:0] a,
                        input logic [DW_B-1:0] b, input logic [DATA_WIDTH-1:0] d,
                        input bit rdy, input bit r);
        exp_t  x;
        beat_t bt;
        bit    pop, acc, lst;
        @(posedge clk);
        #1;
        rst = r; res_valid = v; res_end = e; res_wbAddr = a; res_be = b; res_data = d; wr_ready = rdy;
        x = '{default: 0};
        if (r) begin
            x.rst = 1;
            mq.delete();
            sb.delete();
            m_ovf = 0;
        end else begin
            x.count = mq.size();
            x.wr_en = mq.size() > 0;
            x.idle  = mq.size() == 0 && !v;
            pop = mq.size() > 0 && rdy;
            acc = v && (mq.size() < DEPTH || pop);
            lst = 0;
            if (pop) begin
                lst = mq[0].last;
                void'(mq.pop_front());
            end
            if (acc) begin
                bt = '{addr: a, be: b, data: d, last: e};
                mq.push_back(bt);
                sb.push_back(bt);
            end
            if (v && !acc) m_ovf = 1;
            x.stall_n = mq.size() >= DEPTH - SLACK;
            x.done_n  = pop && lst;
        end
        x.ovf_n = m_ovf;
        exp_q.push_back(x);
    endtask

    exp_t pend;
    bit   have_pend = 0;

    always @(negedge clk) begin
        beat_t h;
        if (have_pend) begin
            chk("stall", longint'(stall), longint'(pend.stall_n));
            chk("instr_done", longint'(instr_done), longint'(pend.done_n));
            chk("overflow_err", longint'(overflow_err), longint'(pend.ovf_n));
            have_pend = 0;
        end
        if (exp_q.size() > 0) begin
            pend = exp_q.pop_front();
            have_pend = 1;
            if (!pend.rst) begin
                chk("wr_en", longint'(wr_en), longint'(pend.wr_en));
                chk("idle", longint'(idle), longint'(pend.idle));
                chk("count", longint'(dut.w_count), longint'(pend.count));
                if (!wr_en) chk("wr_data_idle", longint'(wr_data), 0);
            end
        end
        if (!rst && wr_en === 1'b1 && wr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                h = sb.pop_front();
                chk("wr_addr", longint'(wr_addr), longint'(h.addr));
                chk("wr_be", longint'(wr_be), longint'(h.be));
                chk("wr_data", longint'(wr_data), longint'(h.data));
            end
        end
    end

    initial begin
        logic [DATA_WIDTH-1:0] rd;
        step(0, 0, '0, '0, '0, 0, 1);
        step(0, 0, '0, '0, '0, 0, 0);
        step(0, 0, '0, '0, '0, 1, 0);
        // single beat
        step(1, 1, 5'h12, 8'hFF, 64'hDEAD_BEEF_0000_0012, 1, 0);
        repeat (4) step(0, 0, '0, '0, '0, 1, 0);
        // blocked drain, then overflow, then full push-with-pop
        for (int i = 0; i < 8; i++) step(1, i == 7, 5'(i + 1), 8'h0F, 64'(i), 0, 0);
        step(1, 1, 5'h1F, 8'hAA, 64'h99, 0, 0);
        step(0, 0, '0, '0, '0, 0, 0);
        step(1, 1, 5'h07, 8'h00, 64'h1234, 1, 0);
        repeat (12) step(0, 0, '0, '0, '0, 1, 0);
        // clear the sticky error, then pointer wrap with toggling ready
        step(0, 0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, i % 5 == 4, 5'(i), 8'(i * 3), 64'(100 + i), i % 2 == 0, 0);
        repeat (14) step(0, 0, '0, '0, '0, 1, 0);
        // reset mid-operation with five buffered beats
        for (int i = 0; i < 5; i++) step(1, 1, 5'(i), 8'hFF, 64'(200 + i), 0, 0);
        step(0, 0, '0, '0, '0, 1, 1);
        repeat (3) step(0, 0, '0, '0, '0, 1, 0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            rd = {$urandom(), $urandom()};
            step($urandom_range(0, 99) < 60, $urandom_range(0, 3) == 0, 5'($urandom()),
                 ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom()), rd,
                 $urandom_range(0, 99) < 55, 0);
        end
        repeat (12) step(0, 0, '0, '0, '0, 1, 0);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", longint'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
